// File: rtl/triangle_pkg.sv
// Shared definitions for the triangle stimulus block: coordinate widths,
// packed-vector field offsets and the run-control state encoding.
package triangle_pkg;

   localparam int XW = 11;
   localparam int YW = 10;
   localparam int VW = 4 * (XW + YW);

   // Field offsets of {ax, ay, bx, by, cx, cy, px, py}, MSB first
   localparam int PY_LSB = 0;
   localparam int PX_LSB = PY_LSB + YW;
   localparam int CY_LSB = PX_LSB + XW;
   localparam int CX_LSB = CY_LSB + YW;
   localparam int BY_LSB = CX_LSB + XW;
   localparam int BX_LSB = BY_LSB + YW;
   localparam int AY_LSB = BX_LSB + XW;
   localparam int AX_LSB = AY_LSB + YW;

   typedef enum logic [1:0] {IDLE, SYNC, WAIT_W, DONE} state_t;

   typedef struct packed {
      logic [XW-1:0] ax;
      logic [YW-1:0] ay;
      logic [XW-1:0] bx;
      logic [YW-1:0] by;
      logic [XW-1:0] cx;
      logic [YW-1:0] cy;
      logic [XW-1:0] px;
      logic [YW-1:0] py;
   } vec_t;

   function automatic vec_t unpackVec(input logic [VW-1:0] d);
      vec_t v;
      v.ax = d[AX_LSB +: XW];
      v.ay = d[AY_LSB +: YW];
      v.bx = d[BX_LSB +: XW];
      v.by = d[BY_LSB +: YW];
      v.cx = d[CX_LSB +: XW];
      v.cy = d[CY_LSB +: YW];
      v.px = d[PX_LSB +: XW];
      v.py = d[PY_LSB +: YW];
      return v;
   endfunction

endpackage

// File: rtl/triangle_vec_ram.sv
// Coordinate-vector table: synchronous write from the host, asynchronous
// read so the selected vector is available in the same cycle it is needed.
module triangle_vec_ram
   import triangle_pkg::*;
#(
   parameter int AW    = 4,
   parameter int DEPTH = 16
) (
   input  logic          i_clk,
   input  logic          i_wrEn,
   input  logic [AW-1:0] i_wrAddr,
   input  logic [VW-1:0] i_wrData,
   input  logic [AW-1:0] i_rdAddr,
   output logic [VW-1:0] o_rdData
);

   logic [VW-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
   end

   assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/triangle_stimulus.sv
// Host-side driver for the point-in-triangle tester: walks the vector table
// through the read/write handshake and records one result bit per vector.
module triangle_stimulus
   import triangle_pkg::*;
#(
   parameter int AW    = 4,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [VW-1:0] load_data,
   input  logic [AW:0]   num_vectors,
   input  logic          start,
   input  logic          read,
   input  logic          write,
   input  logic          insideTriangle,
   output logic [XW-1:0] ax,
   output logic [YW-1:0] ay,
   output logic [XW-1:0] bx,
   output logic [YW-1:0] by,
   output logic [XW-1:0] cx,
   output logic [YW-1:0] cy,
   output logic [XW-1:0] px,
   output logic [YW-1:0] py,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   inside_count,
   output logic [AW:0]   outside_count,
   input  logic [AW-1:0] res_addr,
   output logic          res_bit
);

   localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

   state_t           r_state;
   state_t           w_stateNext;
   logic             r_readQ;
   logic             r_writeQ;
   logic [AW-1:0]    r_index;
   logic [AW:0]      r_numVec;
   vec_t             r_vec;
   logic             r_busy;
   logic             r_done;
   logic [AW:0]      r_insideCnt;
   logic [AW:0]      r_outsideCnt;
   logic [DEPTH-1:0] r_result;

   logic             w_rdRise;
   logic             w_wrRise;
   logic             w_idleLike;
   logic             w_start;
   logic             w_capture;
   logic             w_lastVec;
   logic [AW:0]      w_lastIdx;
   logic [AW:0]      w_nvClamped;
   logic             w_nvZero;
   logic [AW-1:0]    w_rdAddr;
   logic [VW-1:0]    w_rdData;
   vec_t             w_vec;

   assign w_rdRise    = read  & ~r_readQ;
   assign w_wrRise    = write & ~r_writeQ;
   assign w_idleLike  = (r_state == IDLE) || (r_state == DONE);
   assign w_start     = start && w_idleLike;
   assign w_capture   = (r_state == WAIT_W) && w_wrRise;
   assign w_lastIdx   = r_numVec - (AW+1)'(1);
   assign w_lastVec   = ({1'b0, r_index} == w_lastIdx);
   assign w_nvClamped = (num_vectors > DEPTH_V) ? DEPTH_V : num_vectors;
   assign w_nvZero    = (w_nvClamped == '0);

   // Look one entry ahead while waiting for a result so the next vector is
   // loaded on the same edge the current result is captured.
   assign w_rdAddr = (r_state == WAIT_W) ? r_index + AW'(1) : '0;
   assign w_vec    = unpackVec(w_rdData);

   triangle_vec_ram #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_ram (
      .i_clk    (clk),
      .i_wrEn   (load_en && w_idleLike),
      .i_wrAddr (load_addr),
      .i_wrData (load_data),
      .i_rdAddr (w_rdAddr),
      .o_rdData (w_rdData)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE, DONE: if (start) w_stateNext = w_nvZero ? DONE : SYNC;
         SYNC:       if (w_rdRise) w_stateNext = WAIT_W;
         WAIT_W:     if (w_wrRise && w_lastVec) w_stateNext = DONE;
         default:    w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_readQ      <= 1'b0;
         r_writeQ     <= 1'b0;
         r_index      <= '0;
         r_numVec     <= '0;
         r_vec        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_insideCnt  <= '0;
         r_outsideCnt <= '0;
         r_result     <= '0;
      end else begin
         r_readQ  <= read;
         r_writeQ <= write;
         if (w_start) begin
            r_numVec     <= w_nvClamped;
            r_index      <= '0;
            r_insideCnt  <= '0;
            r_outsideCnt <= '0;
            r_result     <= '0;
            r_busy       <= !w_nvZero;
            r_done       <= w_nvZero;
            if (!w_nvZero) r_vec <= w_vec;
         end else if (w_capture) begin
            r_result[r_index] <= insideTriangle;
            if (insideTriangle) r_insideCnt  <= r_insideCnt + (AW+1)'(1);
            else                r_outsideCnt <= r_outsideCnt + (AW+1)'(1);
            if (w_lastVec) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_index <= r_index + AW'(1);
               r_vec   <= w_vec;
            end
         end
      end
   end

   assign ax            = r_vec.ax;
   assign ay            = r_vec.ay;
   assign bx            = r_vec.bx;
   assign by            = r_vec.by;
   assign cx            = r_vec.cx;
   assign cy            = r_vec.cy;
   assign px            = r_vec.px;
   assign py            = r_vec.py;
   assign busy          = r_busy;
   assign done          = r_done;
   assign inside_count  = r_insideCnt;
   assign outside_count = r_outsideCnt;
   assign res_bit       = r_result[res_addr];

endmodule

// File: tb/tb_triangle_stimulus.sv
// Scoreboard bench for triangle_stimulus: a behavioural tester answers the
// handshake while a monitor checks driven vectors and run totals.
module tb_triangle_stimulus;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_en = 1'b0;
   logic [3:0]  load_addr = '0;
   logic [83:0] load_data = '0;
   logic [4:0]  num_vectors = '0;
   logic        start = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic        insideTriangle = 1'b0;
   logic [10:0] ax, bx, cx, px;
   logic [9:0]  ay, by, cy, py;
   logic        busy, done, res_bit;
   logic [4:0]  inside_count, outside_count;
   logic [3:0]  res_addr = '0;

   int checkCount = 0;
   int passCount  = 0;
   bit testerOn   = 1'b0;

   logic [83:0] modelTable [16];
   bit          modelBits  [16];
   logic [83:0] expQ[$];
   int          expInQ[$];
   int          expOutQ[$];

   triangle_stimulus #(.AW(4), .DEPTH(16)) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .num_vectors(num_vectors), .start(start),
      .read(read), .write(write), .insideTriangle(insideTriangle),
      .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy), .px(px), .py(py),
      .busy(busy), .done(done), .inside_count(inside_count),
      .outside_count(outside_count), .res_addr(res_addr), .res_bit(res_bit)
   );

   always #5 clk = ~clk;

   function automatic logic [83:0] makeVec(input int ax_, input int ay_, input int bx_, input int by_,
                                           input int cx_, input int cy_, input int px_, input int py_);
      return {11'(ax_), 10'(ay_), 11'(bx_), 10'(by_), 11'(cx_), 10'(cy_), 11'(px_), 10'(py_)};
   endfunction

   function automatic logic [83:0] randVec();
      return makeVec($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
                     $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
                     $urandom_range(0, 40), $urandom_range(0, 40));
   endfunction

   function automatic longint edgeSide(input longint x1, input longint y1, input longint x2,
                                       input longint y2, input longint x3, input longint y3);
      return (x1 - x3) * (y2 - y3) - (x2 - x3) * (y1 - y3);
   endfunction

   // Point counts as inside when it lies on the same side of all three edges (edges included)
   function automatic bit insideOf(input logic [83:0] v);
      longint vax, vay, vbx, vby, vcx, vcy, vpx, vpy, d1, d2, d3;
      vax = longint'(v[83:73]); vay = longint'(v[72:63]);
      vbx = longint'(v[62:52]); vby = longint'(v[51:42]);
      vcx = longint'(v[41:31]); vcy = longint'(v[30:21]);
      vpx = longint'(v[20:10]); vpy = longint'(v[9:0]);
      d1 = edgeSide(vpx, vpy, vax, vay, vbx, vby);
      d2 = edgeSide(vpx, vpy, vbx, vby, vcx, vcy);
      d3 = edgeSide(vpx, vpy, vcx, vcy, vax, vay);
      return !(((d1 < 0) || (d2 < 0) || (d3 < 0)) && ((d1 > 0) || (d2 > 0) || (d3 > 0)));
   endfunction

   task automatic checkOutput(input string name, input logic [83:0] actual, input logic [83:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
   endtask

   task automatic loadEntry(input int addr, input logic [83:0] data);
      @(posedge clk); #1;
      load_en = 1'b1; load_addr = 4'(addr); load_data = data;
      @(posedge clk); #1;
      load_en = 1'b0;
      modelTable[addr] = data;
   endtask

   // Pushes the vectors and totals the run should produce, then pulses start
   task automatic applyStimulus(input int nv);
      int n, ins, outs;
      n = (nv > 16) ? 16 : nv;
      ins = 0; outs = 0;
      for (int i = 0; i < 16; i++) modelBits[i] = 1'b0;
      for (int i = 0; i < n; i++) begin
         expQ.push_back(modelTable[i]);
         modelBits[i] = insideOf(modelTable[i]);
         if (modelBits[i]) ins++; else outs++;
      end
      expInQ.push_back(ins);
      expOutQ.push_back(outs);
      @(posedge clk); #1;
      num_vectors = 5'(nv); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("runDone", 84'(done), 84'd1);
      testerOn = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   task automatic checkBitmap();
      for (int i = 0; i < 16; i++) begin
         res_addr = 4'(i);
         #1;
         checkOutput($sformatf("resBit%0d", i), 84'(res_bit), 84'(modelBits[i]));
      end
   endtask

   // Behavioural tester: read, compute on the sampled operands, pulse write
   initial forever begin
      logic [83:0] sampled;
      @(posedge clk);
      if (testerOn) begin
         #1 read = 1'b1;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         sampled = {ax, ay, bx, by, cx, cy, px, py};
         @(posedge clk); #1;
         read = 1'b0; write = 1'b1; insideTriangle = insideOf(sampled);
         @(posedge clk); #1;
         write = 1'b0;
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
   end

   // Monitor: vector on each operand request, stability under read, totals on done
   logic [83:0] prevVec = '0;
   logic readPrev = 1'b0, writePrev = 1'b0, writePrev2 = 1'b0;
   logic busyPrev = 1'b0, startPrev = 1'b0, donePrev = 1'b0;
   always @(negedge clk) begin
      logic [83:0] curVec;
      curVec = {ax, ay, bx, by, cx, cy, px, py};
      if (readPrev && busyPrev && busy && !startPrev && !(writePrev && !writePrev2))
         checkOutput("coordStable", curVec, prevVec);
      if (read && !readPrev && busy) begin
         if (expQ.size() == 0) checkOutput("vecQueued", 84'd0, 84'd1);
         else checkOutput("vecOnRead", curVec, expQ.pop_front());
      end
      if (done && !donePrev) begin
         if (expInQ.size() == 0) checkOutput("doneQueued", 84'd0, 84'd1);
         else begin
            checkOutput("insideCount", 84'(inside_count), 84'(expInQ.pop_front()));
            checkOutput("outsideCount", 84'(outside_count), 84'(expOutQ.pop_front()));
            checkOutput("busyAtDone", 84'(busy), 84'd0);
            checkOutput("vecsConsumed", 84'(expQ.size()), 84'd0);
         end
      end
      prevVec = curVec; readPrev = read; writePrev2 = writePrev; writePrev = write;
      busyPrev = busy; startPrev = start; donePrev = done;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #3 reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rstBusy", 84'(busy), 84'd0);
      checkOutput("rstDone", 84'(done), 84'd0);
      checkOutput("rstCounts", 84'({inside_count, outside_count}), 84'd0);
      checkOutput("rstCoords", {ax, ay, bx, by, cx, cy, px, py}, 84'd0);
      checkOutput("rstResBit", 84'(res_bit), 84'd0);
      @(posedge clk); #1 reset = 1'b1;

      // Zero-length run: done one cycle after start, nothing driven
      applyStimulus(0);
      @(negedge clk);
      checkOutput("nv0Done", 84'(done), 84'd1);
      checkOutput("nv0Busy", 84'(busy), 84'd0);
      checkOutput("nv0Coords", {ax, ay, bx, by, cx, cy, px, py}, 84'd0);

      // Single inside point
      loadEntry(0, makeVec(0, 0, 10, 0, 0, 10, 2, 2));
      applyStimulus(1);
      testerOn = 1'b1;
      waitDone();
      checkBitmap();

      // Inside/outside mix
      loadEntry(1, makeVec(0, 0, 10, 0, 0, 10, 20, 20));
      loadEntry(2, makeVec(0, 0, 10, 0, 0, 10, 1, 1));
      applyStimulus(3);
      testerOn = 1'b1;
      waitDone();
      checkBitmap();

      // Start while the tester already has a result in flight
      @(posedge clk); #1 read = 1'b1;
      applyStimulus(3);
      @(posedge clk); #1;
      write = 1'b1; insideTriangle = 1'b1;
      @(posedge clk); #1;
      write = 1'b0; read = 1'b0;
      @(negedge clk);
      checkOutput("syncIgnoredWrite", 84'(inside_count + outside_count), 84'd0);
      checkOutput("syncBusy", 84'(busy), 84'd1);
      testerOn = 1'b1;
      waitDone();
      checkBitmap();

      // start and load_en while busy are ignored; restart from DONE resets counts
      for (int i = 0; i < 4; i++) loadEntry(i, randVec());
      applyStimulus(4);
      testerOn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; num_vectors = 5'd1; load_en = 1'b1; load_addr = 4'd0; load_data = ~modelTable[0];
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0;
      waitDone();
      checkBitmap();
      applyStimulus(4);
      testerOn = 1'b1;
      waitDone();
      checkBitmap();

      // Oversized request clamps to the full table
      for (int i = 0; i < 16; i++) loadEntry(i, randVec());
      applyStimulus(20);
      testerOn = 1'b1;
      waitDone();
      checkBitmap();

      // Asynchronous reset in the middle of a run
      applyStimulus(4);
      testerOn = 1'b1;
      for (int n = 0; n < 500 && (inside_count + outside_count) < 2; n++) @(negedge clk);
      checkOutput("midRunProgress", 84'(inside_count + outside_count >= 2), 84'd1);
      testerOn = 1'b0;
      @(negedge clk); #2 reset = 1'b0;
      #1;
      res_addr = 4'd0;
      checkOutput("asyncRstBusy", 84'(busy), 84'd0);
      checkOutput("asyncRstCounts", 84'({inside_count, outside_count}), 84'd0);
      checkOutput("asyncRstCoords", {ax, ay, bx, by, cx, cy, px, py}, 84'd0);
      #1;
      checkOutput("asyncRstResBit", 84'(res_bit), 84'd0);
      expQ.delete(); expInQ.delete(); expOutQ.delete();
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      read = 1'b0; write = 1'b0;
      @(posedge clk); #1 write = 1'b1; insideTriangle = 1'b1;
      @(posedge clk); #1 write = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("postRstCounts", 84'({inside_count, outside_count}), 84'd0);
      checkOutput("postRstBusy", 84'(busy), 84'd0);
      checkOutput("postRstDone", 84'(done), 84'd0);

      // Recovery run after reset
      applyStimulus(2);
      testerOn = 1'b1;
      waitDone();
      checkBitmap();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/triangle_stimulus.md
Name: triangle_stimulus

Overview:
- Host-side partner of the point-in-triangle tester's read/write handshake.
- Holds a small table of coordinate vectors (A, B, C, P) and drives them onto the tester's coordinate inputs.
- Keeps each vector stable from the tester's read request until its write strobe, captures insideTriangle on write, then advances to the next vector.
- Stores a per-vector result bit plus inside/outside counters, read back by the host or bench.

Parameters:
- AW, 4, address width of the vector table.
- DEPTH, 16, number of table entries (2**AW).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  write one table entry this cycle.
- load_addr  in  AW  table entry index.
- load_data  in  84  packed {ax[10:0], ay[9:0], bx[10:0], by[9:0], cx[10:0], cy[9:0], px[10:0], py[9:0]}, MSB first.
- num_vectors  in  AW+1  vectors to run; legal range 0..DEPTH.
- start  in  1  one-cycle pulse that begins a run.
- read  in  1  tester "ready for operands".
- write  in  1  tester "result valid".
- insideTriangle  in  1  tester result.
- ax, bx, cx, px  out  11  X coordinates driven to the tester.
- ay, by, cy, py  out  10  Y coordinates driven to the tester.
- busy  out  1  run in progress.
- done  out  1  run finished; sticky until the next start.
- inside_count  out  AW+1  results equal to 1.
- outside_count  out  AW+1  results equal to 0.
- res_addr  in  AW  result bitmap read index.
- res_bit  out  1  combinational read of result[res_addr].

Behaviour:
- Reset (async, reset=0) clears:
  - state to IDLE, index to 0.
  - all coordinate outputs, busy, done, inside_count, outside_count, result bitmap, read_q, write_q.
- Table contents are not reset.
- Edge detection: read_q and write_q are registered copies of read and write.
  - rd_rise = read & ~read_q; wr_rise = write & ~write_q.
  - Both are combinational, so they act in the same cycle the level is first seen.
- IDLE:
  - load_en writes table[load_addr].
  - start with num_vectors=0: go to DONE, done=1, no vectors driven.
  - start with num_vectors>0: clear counts and bitmap, index=0, drive table[0] on the next edge, busy=1, go to SYNC.
- SYNC:
  - Discards any computation already running in the tester.
  - Waits for rd_rise, then goes to WAIT_W.
  - wr_rise seen in SYNC is ignored.
- WAIT_W: on wr_rise:
  - Set result[index] = insideTriangle.
  - Increment inside_count if insideTriangle=1, otherwise outside_count.
  - If index == num_vectors-1: go to DONE, busy=0, done=1; coordinates keep holding the last vector.
  - Otherwise: index+1, drive table[index+1] on that same edge so outputs are valid by the tester's next operand-sampling cycle; stay in WAIT_W.
- DONE:
  - done held at 1.
  - load_en accepted.
  - start behaves exactly as in IDLE; done clears on that start.
- Latency: coordinate outputs change exactly 1 clk after the start pulse or wr_rise. They change at no other time.
- Handshake rules:
  - Outputs never change while read=1 unless a wr_rise occurs in that same cycle.
  - read and write high together: both edges are evaluated. wr_rise has priority in WAIT_W; rd_rise matters only in SYNC.
- While busy:
  - load_en is ignored; table is unchanged.
  - start is ignored.
  - num_vectors is latched at start; later changes have no effect.
- Counters: inside_count + outside_count == number of captured results. The maximum value DEPTH fits in AW+1 bits, so there is no wrap.
- num_vectors > DEPTH: clamp to DEPTH at start.
- Reset asserted mid-run: immediate return to the IDLE reset state. A subsequent tester write is ignored.

Decomposition:
- Shared package triangle_pkg holds:
  - coordinate widths XW=11 and YW=10;
  - the 84-bit packed-vector field offsets;
  - state encoding IDLE/SYNC/WAIT_W/DONE.
- Optional sub-module triangle_vec_ram: DEPTH x 84 table, synchronous write, asynchronous read indexed by index.

Test Plan:
- Single inside point: load entry 0 with A(0,0) B(10,0) C(0,10) P(2,2), num_vectors=1, start, behavioural tester model attached -> after one write, res_bit[0]=1, inside_count=1, outside_count=0, done=1, busy=0.
- Inside/outside mix: entries 0..2 with P=(2,2), (20,20), (1,1) on the same triangle, num_vectors=3 -> bitmap 1,0,1; inside_count=2; outside_count=1; ax..py change only 1 clk after each write rise.
- Synchronisation: assert start while the tester model has write due in 2 cycles -> that write is ignored; the first result is captured only after the next read rise.
- num_vectors=0 -> done=1 one cycle after start, counts 0, coordinates unchanged. num_vectors=20 -> clamped, exactly 16 results captured.
- start and load_en while busy -> both ignored, and table entry readback afterwards is unchanged. Repeat start in DONE -> counts restart from 0.
- Async reset low mid-run (after 2 of 4 results) -> all outputs 0 immediately, no clock needed. A later write pulse leaves counts at 0 and state IDLE.
